pulsegap_gen: RTL and testbench

Parametrised, programmable pulse/gap pattern generator. It is the next generation of the 16-bit circular shift register used for fixed pulse/gap waveforms such as 11 high over 5 low.
- Adds width parametrisation, a repeat count with completion, hold, a period strobe and status outputs.
- Drives a serial waveform to downstream timing and LED-blink logic in the lab designs.

---
 rtl/pulsegap_gen.sv | 92 +++++++++
 tb/tb_pulsegap_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pulsegap_gen.sv
// Programmable pulse/gap pattern generator: rotates a WIDTH-bit pattern out serially,
// optionally for a fixed number of periods. Define PULSEGAP_DIR_EN to add the dir port.
module pulsegap_gen #(
  parameter int   WIDTH      = 16,
  parameter int   REP_W      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_in,
  input  logic [REP_W-1:0] reps_in,
  input  logic             hold,
`ifdef PULSEGAP_DIR_EN
  input  logic             dir,
`endif
  output logic             shift_out,
  output logic             period_tick,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] period_cnt
);

  localparam int BP_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_pattern;
  logic [BP_W-1:0]  r_bitpos;
  logic [REP_W-1:0] r_period_cnt;
  logic [REP_W-1:0] r_reps;

  logic             w_dir;
  logic             w_run;
  logic             w_last_bit;
  logic             w_final_period;
  logic             w_cnt_sat;
  logic [WIDTH-1:0] w_rotated;

`ifdef PULSEGAP_DIR_EN
  assign w_dir = dir;
`else
  assign w_dir = 1'b0;
`endif

  assign w_run      = (r_state == S_RUN);
  assign w_last_bit = (r_bitpos == BP_W'(WIDTH - 1));
  assign w_cnt_sat  = (r_period_cnt == {REP_W{1'b1}});

  // Widened compare so the final-period test cannot alias through a wrapped sum.
  assign w_final_period = (r_reps != '0) &&
                          (({1'b0, r_period_cnt} + (REP_W+1)'(1)) == {1'b0, r_reps});

  assign w_rotated = w_dir ? {r_pattern[0], r_pattern[WIDTH-1:1]}
                           : {r_pattern[WIDTH-2:0], r_pattern[WIDTH-1]};

  assign shift_out   = w_run ? (w_dir ? r_pattern[0] : r_pattern[WIDTH-1]) : IDLE_LEVEL;
  assign period_tick = w_run && w_last_bit;
  assign busy        = w_run;
  assign done        = (r_state == S_DONE);
  assign period_cnt  = r_period_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pattern    <= '0;
      r_bitpos     <= '0;
      r_period_cnt <= '0;
      r_reps       <= '0;
    end else if (load) begin
      r_state      <= S_RUN;
      r_pattern    <= load_in;
      r_bitpos     <= '0;
      r_period_cnt <= '0;
      r_reps       <= reps_in;
    end else if (w_run && !hold) begin
      r_pattern <= w_rotated;
      if (w_last_bit) begin
        r_bitpos <= '0;
        if (!w_cnt_sat) r_period_cnt <= r_period_cnt + REP_W'(1);
        if (w_final_period) r_state <= S_DONE;
      end else begin
        r_bitpos <= r_bitpos + BP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pulsegap_gen.sv
// Randomized and directed bench for pulsegap_gen against a period/offset arithmetic model.
// Works with or without PULSEGAP_DIR_EN defined.
module tb_pulsegap_gen;

  localparam int W     = 16;
  localparam int REP_W = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             load;
  logic [W-1:0]     load_in;
  logic [REP_W-1:0] reps_in;
  logic             hold;
  logic             tb_dir;
`ifdef PULSEGAP_DIR_EN
  logic             dir;
`endif
  logic             shift_out;
  logic             period_tick;
  logic             busy;
  logic             done;
  logic [REP_W-1:0] period_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: loaded pattern, repeat count, steps taken since load, net left rotations.
  logic             m_loaded;
  logic [W-1:0]     m_pat;
  logic [REP_W-1:0] m_reps;
  int               m_k;
  int               m_rot;

  pulsegap_gen #(.WIDTH(W), .REP_W(REP_W), .IDLE_LEVEL(1'b0)) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_in    (load_in),
    .reps_in    (reps_in),
    .hold       (hold),
`ifdef PULSEGAP_DIR_EN
    .dir        (dir),
`endif
    .shift_out  (shift_out),
    .period_tick(period_tick),
    .busy       (busy),
    .done       (done),
    .period_cnt (period_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic m_run();
    return m_loaded && !((m_reps != '0) && (m_k >= int'(m_reps) * W));
  endfunction

  function automatic int wrap(input int x);
    return ((x % W) + W) % W;
  endfunction

  function automatic logic m_bit();
    if (!m_run()) return 1'b0;
    // Pattern is the original rotated left by m_rot; pick MSB (dir=0) or LSB (dir=1).
    return tb_dir ? m_pat[wrap(-m_rot)] : m_pat[wrap(W - 1 - m_rot)];
  endfunction

  task automatic check_all();
    int p;
    p = m_k / W;
    if (p > 255) p = 255;
    check("shift_out",   {31'd0, shift_out},   {31'd0, m_bit()});
    check("period_tick", {31'd0, period_tick}, {31'd0, m_run() && (m_k % W == W - 1)});
    check("busy",        {31'd0, busy},        {31'd0, m_run()});
    check("done",        {31'd0, done},        {31'd0, m_loaded && !m_run()});
    check("period_cnt",  {24'd0, period_cnt},  m_loaded ? p : 0);
  endtask

  task automatic tick(input logic l, input logic [W-1:0] li, input logic [REP_W-1:0] ri,
                      input logic h);
    load    = l;
    load_in = li;
    reps_in = ri;
    hold    = h;
`ifdef PULSEGAP_DIR_EN
    dir     = tb_dir;
`endif
    @(posedge clock);
    if (l) begin
      m_loaded = 1'b1; m_pat = li; m_reps = ri; m_k = 0; m_rot = 0;
    end else if (m_run() && !h) begin
      m_k++;
      m_rot += tb_dir ? -1 : 1;
    end
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; load_in = '0; reps_in = '0; hold = 1'b0; tb_dir = 1'b0;
`ifdef PULSEGAP_DIR_EN
    dir = 1'b0;
`endif
    m_loaded = 1'b0; m_pat = '0; m_reps = '0; m_k = 0; m_rot = 0;
    #1;
    check_all();
    check("reset_pattern", {16'd0, dut.r_pattern}, 32'd0);
    #13 reset = 1'b0;

    // Free-running 11 high / 5 low.
    tick(1'b1, 16'hFFE0, 8'd0, 1'b0);
    run(40);

    // Two periods then done; pattern back to the loaded value.
    tick(1'b1, 16'hFFE0, 8'd2, 1'b0);
    run(36);
    check("pattern_after_done", {16'd0, dut.r_pattern}, 32'h0000FFE0);

    // Hold for 5 cycles at bit 3 of a single-period run.
    tick(1'b1, 16'hFFE0, 8'd1, 1'b0);
    run(3);
    for (int i = 0; i < 5; i++) tick(1'b0, '0, '0, 1'b1);
    run(16);

    // Reload mid-run at bitpos 9.
    tick(1'b1, 16'hFFE0, 8'd0, 1'b0);
    run(9);
    tick(1'b1, 16'hAAAA, 8'd0, 1'b0);
    run(20);

    // Constant patterns.
    tick(1'b1, 16'h0000, 8'd1, 1'b0);
    run(18);
    tick(1'b1, 16'hFFFF, 8'd1, 1'b0);
    run(18);

    // Asynchronous reset between edges.
    tick(1'b1, 16'hFFE0, 8'd0, 1'b0);
    run(4);
    #2 reset = 1'b1;
    m_loaded = 1'b0; m_k = 0; m_rot = 0;
    #1;
    check_all();
    reset = 1'b0;
    run(5);

`ifdef PULSEGAP_DIR_EN
    tb_dir = 1'b1;
    tick(1'b1, 16'h0001, 8'd0, 1'b0);
    run(34);
    tb_dir = 1'b0;
    tick(1'b1, 16'h0001, 8'd0, 1'b0);
    run(34);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
`ifdef PULSEGAP_DIR_EN
      tb_dir = ($urandom_range(0, 7) == 0) ? ~tb_dir : tb_dir;
`endif
      tick(($urandom_range(0, 19) == 0), W'($urandom), REP_W'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0));
    end

    // Period counter saturation on an endless run.
    tb_dir = 1'b0;
    tick(1'b1, 16'hFFE0, 8'd0, 1'b0);
    run(256 * W + 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
